// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU: decodes to ALU function codes,
// inserts load-use bubbles, and forwards EX/MEM and MEM/WB results onto the ALU operands.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [5:0]    id_opcode,
    input  logic [5:0]    id_funct,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          stall_out,
    output logic [DW-1:0] ex_dataA,
    output logic [DW-1:0] ex_dataB,
    output logic [5:0]    ex_signal,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_regwrite,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_branch,
    output logic          ex_valid
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          mem_read;
        logic          mem_write;
        logic          branch;
        logic          use_imm;
        logic [5:0]    signal;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] dest;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
    } ex_reg_t;

    ex_reg_t ex_q, ex_d, bubble;

    logic          dec_legal, dec_uses_rt, dec_wb, dec_mr, dec_mw, dec_br, dec_use_imm;
    logic [5:0]    dec_signal;
    logic [RW-1:0] dec_dest;
    logic [DW-1:0] dec_imm, rs_cap, rt_cap;
    logic          load_use;
    logic [DW-1:0] fwd_rs, fwd_rt;

    always_comb begin
        bubble        = '0;
        bubble.signal = FN_ADD;
    end

    always_comb begin
        dec_legal   = 1'b0;
        dec_uses_rt = 1'b0;
        dec_wb      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_br      = 1'b0;
        dec_use_imm = 1'b0;
        dec_signal  = FN_ADD;
        dec_dest    = '0;
        dec_imm     = id_imm;
        case (id_opcode)
            OP_RTYPE: begin
                if (id_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
                    dec_legal   = 1'b1;
                    dec_uses_rt = 1'b1;
                    dec_signal  = id_funct;
                    dec_dest    = id_rd;
                    dec_wb      = 1'b1;
                end
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                dec_legal   = 1'b1;
                dec_use_imm = 1'b1;
                dec_dest    = id_rt;
                dec_wb      = 1'b1;
                dec_signal  = (id_opcode == OP_ADDI) ? FN_ADD :
                              (id_opcode == OP_SLTI) ? FN_SLT :
                              (id_opcode == OP_ANDI) ? FN_AND : FN_OR;
                // Logical immediates are zero-extended, arithmetic ones stay sign-extended.
                if (id_opcode == OP_ANDI || id_opcode == OP_ORI)
                    dec_imm = {{(DW-16){1'b0}}, id_imm[15:0]};
            end
            OP_LW: begin
                dec_legal   = 1'b1;
                dec_use_imm = 1'b1;
                dec_dest    = id_rt;
                dec_wb      = 1'b1;
                dec_mr      = 1'b1;
            end
            OP_SW: begin
                dec_legal   = 1'b1;
                dec_uses_rt = 1'b1;
                dec_use_imm = 1'b1;
                dec_mw      = 1'b1;
            end
            OP_BEQ: begin
                dec_legal   = 1'b1;
                dec_uses_rt = 1'b1;
                dec_signal  = FN_SUB;
                dec_br      = 1'b1;
            end
            default: ;
        endcase
    end

    // Register-file write in WB happens the same cycle as this read, so bypass it here.
    assign rs_cap = (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs) ? memwb_result : id_rs_data;
    assign rt_cap = (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rt) ? memwb_result : id_rt_data;

    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.dest != '0) && id_valid && dec_legal &&
                      ((ex_q.dest == id_rs) || (dec_uses_rt && ex_q.dest == id_rt));
    assign stall_out = load_use && !flush;

    always_comb begin
        ex_d = bubble;
        if (!flush && !load_use && id_valid && dec_legal) begin
            ex_d.valid     = 1'b1;
            ex_d.regwrite  = dec_wb && (dec_dest != '0);
            ex_d.mem_read  = dec_mr;
            ex_d.mem_write = dec_mw;
            ex_d.branch    = dec_br;
            ex_d.use_imm   = dec_use_imm;
            ex_d.signal    = dec_signal;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.dest      = dec_dest;
            ex_d.rs_data   = rs_cap;
            ex_d.rt_data   = rt_cap;
            ex_d.imm       = dec_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            ex_q <= bubble;
        else
            ex_q <= ex_d;
    end

    // Youngest producer wins; $0 is hard-wired zero and never takes a forwarded value.
    always_comb begin
        if (exmem_regwrite && exmem_rd != '0 && exmem_rd == ex_q.rs)
            fwd_rs = exmem_result;
        else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == ex_q.rs)
            fwd_rs = memwb_result;
        else
            fwd_rs = ex_q.rs_data;

        if (exmem_regwrite && exmem_rd != '0 && exmem_rd == ex_q.rt)
            fwd_rt = exmem_result;
        else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == ex_q.rt)
            fwd_rt = memwb_result;
        else
            fwd_rt = ex_q.rt_data;
    end

    assign ex_dataA      = fwd_rs;
    assign ex_store_data = fwd_rt;
    assign ex_dataB      = ex_q.use_imm ? ex_q.imm : fwd_rt;
    assign ex_signal     = ex_q.signal;
    assign ex_dest       = ex_q.dest;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_valid      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: an instruction-level reference model checked on every cycle,
// directed scenarios with literal expectations, then randomized instruction streams.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, id_valid, flush;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall_out;
    logic [31:0] ex_dataA, ex_dataB, ex_store_data;
    logic [5:0]  ex_signal;
    logic [4:0]  ex_dest;
    logic        ex_regwrite, ex_mem_read, ex_mem_write, ex_branch, ex_valid;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall_out(stall_out), .ex_dataA(ex_dataA), .ex_dataB(ex_dataB), .ex_signal(ex_signal),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
        .ex_valid(ex_valid)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: the instruction sitting in EX ----------------
    typedef struct {
        bit          v, wb, mr, mw, br, ui;
        int          sig, rs, rt, dest;
        logic [31:0] a, b, imm;
    } slot_t;

    slot_t m_slot;

    function automatic slot_t m_bubble();
        slot_t s;
        s = '{default: 0};
        s.sig = 32;
        return s;
    endfunction

    function automatic bit m_legal(input int op, input int fn);
        if (op == 0) return fn inside {32, 34, 36, 37, 42};
        return op inside {4, 8, 10, 12, 13, 35, 43};
    endfunction

    function automatic bit m_uses_rt(input int op);
        return op == 0 || op == 43 || op == 4;
    endfunction

    function automatic bit m_load_use(input slot_t s);
        if (!(s.v && s.mr && s.dest != 0 && id_valid && m_legal(id_opcode, id_funct))) return 0;
        return s.dest == id_rs || (m_uses_rt(id_opcode) && s.dest == id_rt);
    endfunction

    function automatic logic [31:0] m_wb_bypass(input int idx, input logic [31:0] rf);
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
        return rf;
    endfunction

    function automatic logic [31:0] m_fwd(input int idx, input logic [31:0] held);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
        return held;
    endfunction

    function automatic slot_t m_next();
        slot_t s;
        int op;
        op = id_opcode;
        if (reset || flush || m_load_use(m_slot) || !id_valid || !m_legal(op, id_funct))
            return m_bubble();
        s = m_bubble();
        s.v  = 1;
        s.rs = id_rs;
        s.rt = id_rt;
        s.a  = m_wb_bypass(id_rs, id_rs_data);
        s.b  = m_wb_bypass(id_rt, id_rt_data);
        case (op)
            0:          s.sig = id_funct;
            12:         s.sig = 36;
            13:         s.sig = 37;
            10:         s.sig = 42;
            4:          s.sig = 34;
            default:    s.sig = 32;
        endcase
        if (op == 0) s.dest = id_rd;
        else if (op inside {8, 10, 12, 13, 35}) s.dest = id_rt;
        else s.dest = 0;
        s.imm = (op == 12 || op == 13) ? (id_imm & 32'h0000_FFFF) : id_imm;
        s.ui  = !(op == 0 || op == 4);
        s.wb  = s.dest != 0;
        s.mr  = op == 35;
        s.mw  = op == 43;
        s.br  = op == 4;
        return s;
    endfunction

    always @(posedge clk) m_slot <= m_next();

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] st;
            st = m_fwd(m_slot.rt, m_slot.b);
            chk("stall_out", 32'(stall_out), 32'(m_load_use(m_slot) && !flush));
            chk("ex_valid", 32'(ex_valid), 32'(m_slot.v));
            chk("ex_signal", 32'(ex_signal), 32'(m_slot.sig));
            chk("ex_dest", 32'(ex_dest), 32'(m_slot.dest));
            chk("ex_ctrl", {28'd0, ex_regwrite, ex_mem_read, ex_mem_write, ex_branch},
                {28'd0, m_slot.wb, m_slot.mr, m_slot.mw, m_slot.br});
            chk("ex_dataA", ex_dataA, m_fwd(m_slot.rs, m_slot.a));
            chk("ex_store_data", ex_store_data, st);
            chk("ex_dataB", ex_dataB, m_slot.ui ? m_slot.imm : st);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_idle();
        reset = 0; flush = 0; id_valid = 0;
        id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm);
        id_valid = 1; id_opcode = op; id_funct = fn;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic drive_random();
        logic [5:0] ops [12];
        logic [5:0] fns [5];
        ops = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd12, 6'd13, 6'd10, 6'd35, 6'd35, 6'd43, 6'd4, 6'd63};
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        reset          = ($urandom_range(0, 49) == 0);
        flush          = ($urandom_range(0, 7) == 0);
        id_valid       = ($urandom_range(0, 7) != 0);
        id_opcode      = ops[$urandom_range(0, 11)];
        id_funct       = fns[$urandom_range(0, 4)];
        id_rs          = 5'($urandom_range(0, 7));
        id_rt          = 5'($urandom_range(0, 7));
        id_rd          = 5'($urandom_range(0, 7));
        id_rs_data     = $urandom;
        id_rt_data     = $urandom;
        id_imm         = $urandom;
        exmem_regwrite = $urandom_range(0, 1) == 1;
        exmem_rd       = 5'($urandom_range(0, 7));
        exmem_result   = $urandom;
        memwb_regwrite = $urandom_range(0, 1) == 1;
        memwb_rd       = 5'($urandom_range(0, 7));
        memwb_result   = $urandom;
    endtask

    // ---------------- directed scenarios, then random ----------------
    initial begin
        m_slot = m_bubble();
        drive_random();
        reset = 1;
        tick();
        chk_en = 1;

        // reset with random inputs still applied
        sample();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_signal", 32'(ex_signal), 32'd32);
        chk("rst_dataA", ex_dataA, 32'd0);
        chk("rst_dataB", ex_dataB, 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);

        // slt $6,$3,$4
        drive_idle();
        instr(6'd0, 6'd42, 5'd3, 5'd4, 5'd6, 32'd5, 32'd9, 32'd0);
        tick(); drive_idle(); sample();
        chk("slt_signal", 32'(ex_signal), 32'd42);
        chk("slt_dataA", ex_dataA, 32'd5);
        chk("slt_dataB", ex_dataB, 32'd9);
        chk("slt_dest", 32'(ex_dest), 32'd6);
        chk("slt_regwrite", 32'(ex_regwrite), 32'd1);

        // andi zero-extends its immediate
        instr(6'd12, 6'd0, 5'd1, 5'd2, 5'd0, 32'd7, 32'd8, 32'hFFFF_8001);
        tick(); drive_idle(); sample();
        chk("andi_dataB", ex_dataB, 32'h0000_8001);
        chk("andi_signal", 32'(ex_signal), 32'd36);

        // add $2 then sub $5,$2,$2: EX/MEM beats MEM/WB
        instr(6'd0, 6'd32, 5'd1, 5'd1, 5'd2, 32'd1, 32'd1, 32'd0);
        tick();
        instr(6'd0, 6'd34, 5'd2, 5'd2, 5'd5, 32'd1, 32'd1, 32'd0);
        tick(); drive_idle();
        exmem_regwrite = 1; exmem_rd = 5'd2; exmem_result = 32'h10;
        memwb_regwrite = 1; memwb_rd = 5'd2; memwb_result = 32'h20;
        sample();
        chk("fwd_exmem_A", ex_dataA, 32'h10);
        chk("fwd_exmem_B", ex_dataB, 32'h10);
        exmem_regwrite = 0;
        #1;
        chk("fwd_memwb_A", ex_dataA, 32'h20);
        tick(); drive_idle();

        // lw $7 then add $8,$7,$1: one stall, one bubble, then MEM/WB forward
        instr(6'd35, 6'd0, 5'd1, 5'd7, 5'd0, 32'h100, 32'd0, 32'd4);
        tick();
        instr(6'd0, 6'd32, 5'd7, 5'd1, 5'd8, 32'h111, 32'h222, 32'd0);
        sample();
        chk("lu_stall", 32'(stall_out), 32'd1);
        tick();
        exmem_regwrite = 1; exmem_rd = 5'd7; exmem_result = 32'h5555;
        sample();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_stall_once", 32'(stall_out), 32'd0);
        tick(); drive_idle();
        memwb_regwrite = 1; memwb_rd = 5'd7; memwb_result = 32'hABC;
        sample();
        chk("lu_issue_valid", 32'(ex_valid), 32'd1);
        chk("lu_issue_dataA", ex_dataA, 32'hABC);
        tick(); drive_idle();

        // flush during a load-use condition
        instr(6'd35, 6'd0, 5'd1, 5'd7, 5'd0, 32'h100, 32'd0, 32'd4);
        tick();
        instr(6'd0, 6'd32, 5'd7, 5'd1, 5'd8, 32'h111, 32'h222, 32'd0);
        flush = 1;
        sample();
        chk("flush_stall", 32'(stall_out), 32'd0);
        tick(); drive_idle(); sample();
        chk("flush_valid", 32'(ex_valid), 32'd0);

        // write to $0 is dropped and $0 is never forwarded
        instr(6'd8, 6'd0, 5'd1, 5'd0, 5'd0, 32'd3, 32'd0, 32'd5);
        tick();
        instr(6'd0, 6'd32, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0);
        sample();
        chk("r0_regwrite", 32'(ex_regwrite), 32'd0);
        tick(); drive_idle();
        exmem_regwrite = 1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        memwb_regwrite = 1; memwb_rd = 5'd0; memwb_result = 32'hBEEF;
        sample();
        chk("r0_dataA", ex_dataA, 32'd0);
        chk("r0_dataB", ex_dataB, 32'd0);
        tick(); drive_idle();

        // unknown opcode
        instr(6'd63, 6'd32, 5'd1, 5'd3, 5'd4, 32'd1, 32'd2, 32'd3);
        tick(); drive_idle(); sample();
        chk("op63_valid", 32'(ex_valid), 32'd0);
        chk("op63_regwrite", 32'(ex_regwrite), 32'd0);
        chk("op63_signal", 32'(ex_signal), 32'd32);

        // reset asserted during a stall
        instr(6'd35, 6'd0, 5'd1, 5'd7, 5'd0, 32'h100, 32'd0, 32'd4);
        tick();
        instr(6'd0, 6'd32, 5'd7, 5'd1, 5'd8, 32'h111, 32'h222, 32'd0);
        sample();
        chk("rststall_pre", 32'(stall_out), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        sample();
        chk("rststall_stall", 32'(stall_out), 32'd0);
        chk("rststall_valid", 32'(ex_valid), 32'd0);

        // randomized instruction streams
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive_random();
        end
        tick();
        drive_idle();
        tick();
        sample();
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
